slc3_key_conditioner: RTL and testbench
=======================================

# slc3_key_conditioner

Input conditioning stage directly upstream of the SLC-3 state controller. It takes the raw, active-low, asynchronous push-button lines for Run and Continue (plus spare keys) and makes them usable by the ISDU. Each line is synchronized and debounced, producing a clean active-high level plus one-cycle press and release strobes. The ISDU's Run/Continue inputs are driven from `key_level`; the strobes are for single-step logic and LED feedback.

## Interface
- `N_KEYS`, default 2: number of independent key channels; bit 0 = Run, bit 1 = Continue.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Legal values are ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: width of the per-channel counter.
- `Clk`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset for the whole block.
- `key_n_raw`  input  N_KEYS  raw push-buttons, active-low, asynchronous to `Clk`.
- `key_level`  output  N_KEYS  debounced key state, active-high (1 = held).
- `key_press`  output  N_KEYS  one-cycle strobe when a channel's accepted state becomes held.
- `key_release`  output  N_KEYS  one-cycle strobe when a channel's accepted state becomes released.

## Operation
- Each channel is fully independent: its own 2-flop synchronizer, FSM and counter. There is no cross-channel interaction.
- Synchronizer: `key_n_raw[i]` → `s1[i]` → `s2[i]`. Both flops reset to 1 (released). The FSM sees only `s2`.
- FSM states per channel are RELEASED, PRESS_WAIT, HELD and RELEASE_WAIT.
  - RELEASED: if `s2`=0, go to PRESS_WAIT and clear `cnt` to 0. Otherwise stay.
  - PRESS_WAIT, sampling `s2`:
    - `s2`=1: return to RELEASED and clear `cnt`. This is a bounce; no strobe.
    - `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to HELD.
    - `s2`=0 otherwise: increment `cnt`.
  - HELD: if `s2`=1, go to RELEASE_WAIT and clear `cnt`.
  - RELEASE_WAIT, sampling `s2`:
    - `s2`=0: return to HELD and clear `cnt`.
    - `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to RELEASED.
    - `s2`=1 otherwise: increment `cnt`.
- `key_level[i]` is 1 in HELD and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT. It is registered and never glitches.
- `key_press[i]` is registered and is 1 for exactly the cycle after the PRESS_WAIT→HELD edge.
- `key_release[i]` is registered and is 1 for exactly the cycle after the RELEASE_WAIT→RELEASED edge.
- `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps. `CNT_W` must hold DEBOUNCE_CYCLES-1.
- A key held through reset deassertion is treated as a fresh press: it yields `key_press` after the normal debounce latency.
- Reset mid-operation: any state and any partial count is abandoned immediately. Any strobe in progress is cut off.

## Timing
- Reset values: all outputs 0, `s1`/`s2` = 1, all FSMs in RELEASED, all `cnt` = 0.
- Press latency, with raw low first sampled into `s1` at edge k:
  - `s2`=0 at edge k+1.
  - PRESS_WAIT entered at edge k+2.
  - HELD entered at edge k+2+DEBOUNCE_CYCLES.
  - `key_level` and `key_press` are high starting at that same edge, so both are visible after edge k+2+D.
- Release latency is symmetric: D+2 edges from the first sampled high to the fall of `key_level` and the `key_release` strobe.
- A bounce shorter than D cycles (as seen at `s2`) produces no output change.
- Strobes never last more than 1 cycle. A channel cannot assert press and release in the same cycle.
- Minimum spacing between a `key_press` and the next `key_release` on one channel is D+1 cycles.

## Test plan
- Reset: assert `Reset` with keys idle (`key_n_raw`=2'b11). All outputs are 0. After release, outputs stay 0 for 20 cycles.
- Clean press, D=4: drive `key_n_raw[0]`=0 and hold it.
  - `key_level[0]` rises, and `key_press[0]` pulses for 1 cycle, exactly 6 edges after first sampling.
  - Channel 1 is unaffected.
- Bounce rejection, D=4: drive raw0 low 3 cycles, high 1, low 3, high. No strobe fires and `key_level[0]` stays 0.
- Release with bounce, D=4, key held (`key_level[0]`=1): drive raw0 high 2 cycles, low 1, then high.
  - `key_level[0]` falls and `key_release[0]` pulses 6 edges after the final rising sample.
- Simultaneous keys: press both channels on the same cycle. Both `key_press` bits pulse in the same cycle with identical latency.
- Reset mid-debounce, D=4: assert `Reset` during PRESS_WAIT (`cnt`=2) with the key still held.
  - Outputs stay 0 during reset.
  - After deassertion, the press is detected with the full 6-edge latency, not a shortened one.

Source files
------------

// File: rtl/slc3_key_if.sv
// Key-conditioner signal bundle: raw active-low buttons in, debounced level and strobes out.
interface slc3_key_if #(
    parameter int unsigned N_KEYS = 2
) ();
    logic [N_KEYS-1:0] key_n_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    // master: the button source / downstream consumer; slave: the conditioner itself
    modport master (
        output key_n_raw,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_n_raw,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/slc3_key_conditioner.sv
// Per-key synchronizer + debounce FSM feeding the SLC-3 ISDU Run/Continue inputs.
// Each channel produces a registered active-high level and one-cycle press/release strobes.
module slc3_key_conditioner #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input logic     Clk,
    input logic     Reset,
    slc3_key_if.slave keys
);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] level_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic             s1_q, s2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                s1_q      <= 1'b1;
                s2_q      <= 1'b1;
                state_q   <= StReleased;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1_q      <= keys.key_n_raw[i];
                s2_q      <= s1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // s2_q is active-low: 0 means the button is currently pressed
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (!s2_q) begin
                        state_d = StPressWait;
                        cnt_d   = '0;
                    end
                end
                StPressWait: begin
                    if (s2_q) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StHeld;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StHeld: begin
                    if (s2_q) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end
                end
                StReleaseWait: begin
                    if (!s2_q) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d   = StReleased;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
            level_d = (state_d == StHeld) || (state_d == StReleaseWait);
        end

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_q;
        assign release_w[i] = release_q;
    end

    assign keys.key_level   = level_w;
    assign keys.key_press   = press_w;
    assign keys.key_release = release_w;

endmodule

// File: tb/tb_slc3_key_conditioner.sv
// Randomized and directed checks of slc3_key_conditioner against a run-length debounce model.
module tb_slc3_key_conditioner;

    localparam int D = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    slc3_key_if #(.N_KEYS(2)) bus ();

    slc3_key_conditioner #(
        .N_KEYS         (2),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .keys (bus)
    );

    always #5 Clk = ~Clk;

    // Model: a 2-stage delay, then the accepted level flips once the delayed input has
    // disagreed with it for D+1 consecutive edges.
    logic [1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
    int         run [2];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_s1  <= 2'b11;
            m_s2  <= 2'b11;
            m_lvl <= 2'b00;
            m_prs <= 2'b00;
            m_rel <= 2'b00;
            run   <= '{0, 0};
        end else begin
            m_s1 <= bus.key_n_raw;
            m_s2 <= m_s1;
            for (int i = 0; i < 2; i++) begin
                if (!m_s2[i] != m_lvl[i]) begin
                    run[i]   <= (run[i] == D) ? 0 : run[i] + 1;
                    m_lvl[i] <= (run[i] == D) ? !m_s2[i] : m_lvl[i];
                    m_prs[i] <= (run[i] == D) && !m_s2[i];
                    m_rel[i] <= (run[i] == D) && m_s2[i];
                end else begin
                    run[i]   <= 0;
                    m_prs[i] <= 1'b0;
                    m_rel[i] <= 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.key_n_raw = 2'b11;
        idle(3);
        total++;
        if (bus.key_level !== 2'b00 || bus.key_press !== 2'b00 || bus.key_release !== 2'b00) begin
            bad++;
            $display("FAIL reset_in: got lvl=%b prs=%b rel=%b want 00/00/00",
                     bus.key_level, bus.key_press, bus.key_release);
        end
        Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            total++;
            if (bus.key_level !== 2'b00 || bus.key_press !== 2'b00
                || bus.key_release !== 2'b00) begin
                bad++;
                $display("FAIL reset_idle c=%0d: got lvl=%b prs=%b rel=%b want 00/00/00",
                         c, bus.key_level, bus.key_press, bus.key_release);
            end
        end
    endtask

    task automatic test_clean_press;
        bus.key_n_raw = 2'b10;
        for (int e = 1; e <= 9; e++) begin
            @(negedge Clk);
            total++;
            if (bus.key_level !== ((e >= D + 3) ? 2'b01 : 2'b00)
                || bus.key_press !== ((e == D + 3) ? 2'b01 : 2'b00)
                || bus.key_release !== 2'b00) begin
                bad++;
                $display("FAIL clean_press e=%0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b",
                         e, bus.key_level, bus.key_press, bus.key_release,
                         (e >= D + 3) ? 2'b01 : 2'b00, (e == D + 3) ? 2'b01 : 2'b00);
            end
        end
        bus.key_n_raw = 2'b11;
        idle(12);
    endtask

    task automatic test_bounce;
        logic [7:0] pat;
        pat = 8'b1_0001_000;  // LSB first: low 3, high 1, low 3, then high
        for (int c = 0; c < 20; c++) begin
            bus.key_n_raw = {1'b1, (c < 8) ? pat[c] : 1'b1};
            @(negedge Clk);
            total++;
            if (bus.key_level[0] !== 1'b0 || bus.key_press !== 2'b00
                || bus.key_release !== 2'b00) begin
                bad++;
                $display("FAIL bounce c=%0d: got lvl=%b prs=%b rel=%b want 00/00/00",
                         c, bus.key_level, bus.key_press, bus.key_release);
            end
        end
    endtask

    task automatic test_release_bounce;
        int waited;
        bus.key_n_raw = 2'b10;
        waited = 0;
        while (bus.key_level[0] !== 1'b1 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        total++;
        if (bus.key_level[0] !== 1'b1) begin
            bad++;
            $display("FAIL rel_hold_timeout: got lvl=%b want lvl[0]=1", bus.key_level);
        end
        idle(2);
        bus.key_n_raw = 2'b11;
        idle(2);
        bus.key_n_raw = 2'b10;
        idle(1);
        bus.key_n_raw = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            @(negedge Clk);
            total++;
            if (bus.key_level[0] !== (e < D + 3) || bus.key_release !== ((e == D + 3) ? 2'b01 : 2'b00)
                || bus.key_press !== 2'b00) begin
                bad++;
                $display("FAIL release_bounce e=%0d: got lvl=%b prs=%b rel=%b want lvl0=%0d rel=%b",
                         e, bus.key_level, bus.key_press, bus.key_release, (e < D + 3),
                         (e == D + 3) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_simultaneous;
        bus.key_n_raw = 2'b00;
        for (int e = 1; e <= 9; e++) begin
            @(negedge Clk);
            total++;
            if (bus.key_press !== ((e == D + 3) ? 2'b11 : 2'b00)
                || bus.key_level !== ((e >= D + 3) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL simultaneous e=%0d: got lvl=%b prs=%b want lvl=%b prs=%b",
                         e, bus.key_level, bus.key_press, (e >= D + 3) ? 2'b11 : 2'b00,
                         (e == D + 3) ? 2'b11 : 2'b00);
            end
        end
        bus.key_n_raw = 2'b11;
        idle(12);
    endtask

    task automatic test_reset_mid;
        bus.key_n_raw = 2'b10;
        idle(5);  // PRESS_WAIT entered at edge 3, cnt reaches 2 at edge 5
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            total++;
            if (bus.key_level !== 2'b00 || bus.key_press !== 2'b00 || bus.key_release !== 2'b00) begin
                bad++;
                $display("FAIL reset_mid_hold c=%0d: got lvl=%b prs=%b rel=%b want 00/00/00",
                         c, bus.key_level, bus.key_press, bus.key_release);
            end
        end
        Reset = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(negedge Clk);
            total++;
            if (bus.key_press !== ((e == D + 3) ? 2'b01 : 2'b00)
                || bus.key_level !== ((e >= D + 3) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL reset_mid_after e=%0d: got lvl=%b prs=%b want lvl=%b prs=%b",
                         e, bus.key_level, bus.key_press, (e >= D + 3) ? 2'b01 : 2'b00,
                         (e == D + 3) ? 2'b01 : 2'b00);
            end
        end
        bus.key_n_raw = 2'b11;
        idle(12);
    endtask

    task automatic test_random;
        int hold [2];
        hold = '{0, 0};
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    bus.key_n_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 10));
                end
                hold[i]--;
            end
            @(negedge Clk);
            total++;
            if (bus.key_level !== m_lvl || bus.key_press !== m_prs || bus.key_release !== m_rel
                || (bus.key_press & bus.key_release) !== 2'b00) begin
                bad++;
                $display("FAIL random c=%0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                         c, bus.key_level, bus.key_press, bus.key_release, m_lvl, m_prs, m_rel);
            end
        end
    endtask

    initial begin
        bus.key_n_raw = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        bus.key_n_raw = 2'b11;
        idle(12);
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
